// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle unsigned restoring divider. It is the companion to the
// combinational multiplier datapath. The design has a start/busy/done
// handshake and produces one quotient bit per clock. Results are held in
// output registers until the next result is ready.
//
// Optional feature macro: SEQ_DIVIDER_DIV_ZERO_FLAG_EN
//   When this macro is defined, the module has an extra output div_zero. The
//   flag is loaded together with QUOTIENT/REMAINDER and is set when the
//   captured divisor was zero.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request, sampled only while busy is low
//   DIVIDEND   n_DIVIDEND-bit unsigned dividend, captured with start
//   DIVISOR    n_DIVISOR-bit unsigned divisor, captured with start
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse, QUOTIENT/REMAINDER valid
//   div_zero   (macro only) last result came from a zero divisor
//   QUOTIENT   registered quotient, n_DIVIDEND bits
//   REMAINDER  registered remainder, n_DIVISOR bits
//
// State table:
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | one restoring iteration per cycle, n_DIVIDEND cycles
//   DONE  | done pulse, results loaded on entry, back to IDLE
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int n_DIVIDEND = 16,
    parameter int n_DIVISOR  = 8,
    parameter int n_CNT      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [n_DIVIDEND-1:0] DIVIDEND,
    input  logic [n_DIVISOR-1:0]  DIVISOR,
    output logic                  busy,
    output logic                  done,
`ifdef SEQ_DIVIDER_DIV_ZERO_FLAG_EN
    output logic                  div_zero,
`endif
    output logic [n_DIVIDEND-1:0] QUOTIENT,
    output logic [n_DIVISOR-1:0]  REMAINDER
);

    localparam logic [n_CNT-1:0] CNT_LAST = n_CNT'(n_DIVIDEND - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [n_DIVIDEND-1:0] r_dividend;   // dividend bits shift out, quotient bits shift in
    logic [n_DIVISOR-1:0]  r_divisor;
    // After each step the stored partial remainder is always < divisor, so
    // n_DIVISOR bits hold it. Only the shifted value P' needs the extra bit.
    logic [n_DIVISOR-1:0]  r_prem;
    logic [n_CNT-1:0]      r_cnt;

    logic [n_DIVISOR:0]    w_p_shift;
    logic [n_DIVISOR:0]    w_p_diff;
    logic                  w_ge;
    logic [n_DIVISOR-1:0]  w_p_next;
    logic [n_DIVIDEND-1:0] w_q_next;

    // The stored P is < divisor, so P' <= 2*divisor-1. The difference
    // P' - divisor therefore fits in n_DIVISOR bits when P' >= divisor. When
    // P' < divisor the difference wraps and sets its top bit. That top bit is
    // exactly the borrow of the P' >= {1'b0, divisor} compare.
    always_comb begin
        w_p_shift = {r_prem, r_dividend[n_DIVIDEND-1]};
        w_p_diff  = w_p_shift - {1'b0, r_divisor};
        w_ge      = ~w_p_diff[n_DIVISOR];
        w_p_next  = w_ge ? w_p_diff[n_DIVISOR-1:0] : w_p_shift[n_DIVISOR-1:0];
        w_q_next  = {r_dividend[n_DIVIDEND-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_prem     <= '0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            QUOTIENT   <= '0;
            REMAINDER  <= '0;
`ifdef SEQ_DIVIDER_DIV_ZERO_FLAG_EN
            div_zero   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (DIVISOR == '0) begin
                            // Divide by zero skips CALC and publishes a saturated
                            // quotient. The remainder is the low dividend bits.
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            QUOTIENT  <= '1;
                            REMAINDER <= DIVIDEND[n_DIVISOR-1:0];
`ifdef SEQ_DIVIDER_DIV_ZERO_FLAG_EN
                            div_zero  <= 1'b1;
`endif
                        end else begin
                            r_state    <= S_CALC;
                            r_dividend <= DIVIDEND;
                            r_divisor  <= DIVISOR;
                            r_prem     <= '0;
                            r_cnt      <= '0;
                        end
                    end
                end

                S_CALC: begin
                    r_dividend <= w_q_next;
                    r_prem     <= w_p_next;
                    r_cnt      <= r_cnt + n_CNT'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        QUOTIENT  <= w_q_next;
                        REMAINDER <= w_p_next;
`ifdef SEQ_DIVIDER_DIV_ZERO_FLAG_EN
                        div_zero  <= 1'b0;
`endif
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//
// Directed-vector bench for seq_divider at default parameters. It uses a
// table of operands with hand-computed results. It also has hand-written
// sequences for these cases: start ignored while busy, back-to-back starts,
// reset in the middle of an operation, and a random operand sweep.
// The macro SEQ_DIVIDER_DIV_ZERO_FLAG_EN also enables the div_zero checks.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int N_DVD = 16;
    localparam int N_DVS = 8;
    localparam int N_CNT = 5;

    logic             clk;
    logic             reset;
    logic             start;
    logic [N_DVD-1:0] DIVIDEND;
    logic [N_DVS-1:0] DIVISOR;
    logic             busy;
    logic             done;
    logic [N_DVD-1:0] QUOTIENT;
    logic [N_DVS-1:0] REMAINDER;
`ifdef SEQ_DIVIDER_DIV_ZERO_FLAG_EN
    logic             div_zero;
`endif

    seq_divider #(
        .n_DIVIDEND(N_DVD),
        .n_DIVISOR (N_DVS),
        .n_CNT     (N_CNT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .DIVIDEND (DIVIDEND),
        .DIVISOR  (DIVISOR),
        .busy     (busy),
        .done     (done),
`ifdef SEQ_DIVIDER_DIV_ZERO_FLAG_EN
        .div_zero (div_zero),
`endif
        .QUOTIENT (QUOTIENT),
        .REMAINDER(REMAINDER)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drives start for cycle 0 and scrambles the operands afterwards. It
    // returns at the negedge of the done cycle. cyc is -1 when no done pulse
    // arrives within the budget.
    task automatic run_op(input logic [N_DVD-1:0] a, input logic [N_DVS-1:0] b,
                          output int cyc, output logic [N_DVD-1:0] q, output logic [N_DVS-1:0] r);
        @(negedge clk);
        start    = 1'b1;
        DIVIDEND = a;
        DIVISOR  = b;
        @(negedge clk);
        start    = 1'b0;
        DIVIDEND = N_DVD'($urandom);
        DIVISOR  = N_DVS'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
        q = QUOTIENT;
        r = REMAINDER;
    endtask

    typedef struct {
        logic [N_DVD-1:0] dvd;
        logic [N_DVS-1:0] dvs;
        logic [N_DVD-1:0] q;
        logic [N_DVS-1:0] r;
        int               cyc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               cyc;
        logic [N_DVD-1:0] q;
        logic [N_DVS-1:0] r;
        int               ndone;
        int               d1_cyc, d2_cyc;
        logic [N_DVD-1:0] d1_q, d2_q;
        logic [N_DVS-1:0] d1_r, d2_r;

        vecs[0]  = '{16'd100,   8'd7,   16'd14,    8'd2,    17};
        vecs[1]  = '{16'd65025, 8'd255, 16'd255,   8'd0,    17};
        vecs[2]  = '{16'd65535, 8'd1,   16'd65535, 8'd0,    17};
        vecs[3]  = '{16'h04D2,  8'd0,   16'hFFFF,  8'hD2,   1};
        vecs[4]  = '{16'd9,     8'd4,   16'd2,     8'd1,    17};
        vecs[5]  = '{16'd50,    8'd5,   16'd10,    8'd0,    17};
        vecs[6]  = '{16'd0,     8'd3,   16'd0,     8'd0,    17};
        vecs[7]  = '{16'd255,   8'd16,  16'd15,    8'd15,   17};
        vecs[8]  = '{16'd65535, 8'd255, 16'd257,   8'd0,    17};
        vecs[9]  = '{16'd1000,  8'd3,   16'd333,   8'd1,    17};
        vecs[10] = '{16'd12345, 8'd100, 16'd123,   8'd45,   17};
        vecs[11] = '{16'd7,     8'd9,   16'd0,     8'd7,    17};

        reset    = 1'b1;
        start    = 1'b0;
        DIVIDEND = '0;
        DIVISOR  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q",    32'(QUOTIENT), 32'd0);
        check("rst_r",    32'(REMAINDER), 32'd0);
`ifdef SEQ_DIVIDER_DIV_ZERO_FLAG_EN
        check("rst_dz",   32'(div_zero), 32'd0);
`endif
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, cyc, q, r);
            check($sformatf("v%0d_cyc", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("v%0d_q", i),   32'(q),   32'(vecs[i].q));
            check($sformatf("v%0d_r", i),   32'(r),   32'(vecs[i].r));
`ifdef SEQ_DIVIDER_DIV_ZERO_FLAG_EN
            check($sformatf("v%0d_dz", i), 32'(div_zero), 32'(vecs[i].dvs == '0));
`endif
            if (vecs[i].cyc == 1 || i == 0)
                check($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_done_after", i), 32'(done), 32'd0);
            check($sformatf("v%0d_q_held", i),     32'(QUOTIENT), 32'(vecs[i].q));
        end

        // Start while busy (cycle 5 and the DONE cycle 17) is ignored.
        // A start in cycle 19 is accepted.
        ndone = 0; d1_cyc = -1; d2_cyc = -1;
        d1_q = '0; d2_q = '0; d1_r = '0; d2_r = '0;
        @(negedge clk);
        start = 1'b1; DIVIDEND = 16'd100; DIVISOR = 8'd7;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin d1_cyc = c; d1_q = QUOTIENT; d1_r = REMAINDER; end
                if (ndone == 2) begin d2_cyc = c; d2_q = QUOTIENT; d2_r = REMAINDER; end
            end
            if (c == 1)  check("ign_busy_c1", 32'(busy), 32'd1);
            if (c == 18) begin
                check("ign_busy_c18", 32'(busy), 32'd0);
                check("ign_q_c18", 32'(QUOTIENT), 32'd14);
            end
            if (c == 19) check("ign_busy_c19", 32'(busy), 32'd0);
            if (c == 20) begin
                check("b2b_busy_c20", 32'(busy), 32'd1);
                check("b2b_q_held_c20", 32'(QUOTIENT), 32'd14);
            end
            if (c >= 5) begin DIVIDEND = 16'd50; DIVISOR = 8'd5; end
            start = (c == 5 || c == 17 || c == 19);
        end
        start = 1'b0;
        check("ign_ndone", 32'(ndone), 32'd2);
        check("ign_d1_cyc", 32'(d1_cyc), 32'd17);
        check("ign_d1_q", 32'(d1_q), 32'd14);
        check("ign_d1_r", 32'(d1_r), 32'd2);
        check("b2b_d2_cyc", 32'(d2_cyc), 32'd36);
        check("b2b_d2_q", 32'(d2_q), 32'd10);
        check("b2b_d2_r", 32'(d2_r), 32'd0);

        // Reset in cycle 8 aborts the operation with no done pulse.
        ndone = 0;
        @(negedge clk);
        start = 1'b1; DIVIDEND = 16'd100; DIVISOR = 8'd7;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (c == 7) check("abort_busy_c7", 32'(busy), 32'd1);
            if (c == 9) begin
                check("abort_busy_c9", 32'(busy), 32'd0);
                check("abort_q_c9", 32'(QUOTIENT), 32'd0);
                check("abort_r_c9", 32'(REMAINDER), 32'd0);
            end
            start = 1'b0;
            reset = (c == 8);
        end
        reset = 1'b0;
        check("abort_ndone", 32'(ndone), 32'd0);
        run_op(16'd9, 8'd4, cyc, q, r);
        check("post_abort_cyc", 32'(cyc), 32'd17);
        check("post_abort_q", 32'(q), 32'd2);
        check("post_abort_r", 32'(r), 32'd1);
        @(negedge clk);

        // Random sweep with a non-zero divisor
        for (int k = 0; k < 20; k++) begin
            logic [N_DVD-1:0] a;
            logic [N_DVS-1:0] b;
            a = N_DVD'($urandom_range(0, 65535));
            b = N_DVS'($urandom_range(1, 255));
            run_op(a, b, cyc, q, r);
            check($sformatf("rnd%0d_cyc", k), 32'(cyc), 32'd17);
            check($sformatf("rnd%0d_ident", k), 32'(q) * 32'(b) + 32'(r), 32'(a));
            check($sformatf("rnd%0d_r_lt_d", k), 32'(r < b), 32'd1);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
